// File: rtl/datapath_cfg_ctrl.sv
// datapath_cfg_ctrl: gamma LUT loader and enable sequencer for one datapath channel
module datapath_cfg_ctrl #(
  parameter int DATA_W     = 8,
  parameter int LUT_DEPTH  = 256,
  parameter int PIPE_DEPTH = 4,
  parameter int CP_TIMEOUT = 8
) (
  input  logic              clk,
  input  logic              resetN,
  input  logic              cfg_start,
  input  logic              cfg_g_en,
  input  logic              cfg_c_en,
  input  logic              cfg_b_en,
  output logic [DATA_W-1:0] lut_rd_addr,
  input  logic [DATA_W-1:0] lut_rd_data,
  input  logic              cp_invalid,
  input  logic              pix_valid_in,
  input  logic              pix_last_in,
  output logic              glut_write_en_n,
  output logic [DATA_W-1:0] glut_from,
  output logic [DATA_W-1:0] glut_to,
  output logic              g_en,
  output logic              c_en,
  output logic              b_en,
  output logic              datapath_ready,
  output logic              busy,
  output logic              cfg_done,
  output logic              err_cp
);
  localparam int CW = $clog2(CP_TIMEOUT + 1);
  localparam int FW = $clog2(PIPE_DEPTH + 1);
  localparam logic [CW-1:0] CP_LAST = CW'(CP_TIMEOUT - 1);
  localparam logic [FW-1:0] FL_LAST = FW'(PIPE_DEPTH);
  localparam logic [DATA_W-1:0] ADDR_LAST = DATA_W'(LUT_DEPTH - 1);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_CP, RUN, DRAIN} state_t;
  state_t state;
  logic sg, sc, sb;
  logic rd_v, p_v;
  logic [DATA_W-1:0] p_a;
  logic frame_done;
  logic pix_end;
  logic [CW-1:0] cp_cnt;
  logic [FW-1:0] fl_cnt;
  assign pix_end = pix_valid_in & pix_last_in;
  // Sequencer: rd_v marks an issued RAM read, p_v/p_a delay it one cycle to meet the RAM data
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state           <= IDLE;
      {sg, sc, sb}    <= '0;
      rd_v            <= 1'b0;
      p_v             <= 1'b0;
      p_a             <= '0;
      frame_done      <= 1'b0;
      cp_cnt          <= '0;
      fl_cnt          <= '0;
      lut_rd_addr     <= '0;
      glut_write_en_n <= 1'b1;
      glut_from       <= '0;
      glut_to         <= '0;
      {g_en, c_en, b_en} <= '0;
      datapath_ready  <= 1'b0;
      busy            <= 1'b0;
      cfg_done        <= 1'b0;
      err_cp          <= 1'b0;
    end else begin
      cfg_done <= 1'b0;
      err_cp   <= 1'b0;
      p_v      <= rd_v;
      p_a      <= lut_rd_addr;
      case (state)
        IDLE: if (cfg_start) begin
          {sg, sc, sb} <= {cfg_g_en, cfg_c_en, cfg_b_en};
          lut_rd_addr  <= '0;
          rd_v         <= 1'b1;
          busy         <= 1'b1;
          state        <= LOAD;
        end
        LOAD: begin
          glut_write_en_n <= ~p_v;
          glut_from       <= p_a;
          glut_to         <= lut_rd_data;
          if (rd_v && lut_rd_addr == ADDR_LAST) rd_v <= 1'b0;
          else if (rd_v) lut_rd_addr <= lut_rd_addr + 1'b1;
          if (!rd_v && !p_v && !glut_write_en_n) begin
            cp_cnt <= '0;
            state  <= WAIT_CP;
          end
        end
        WAIT_CP: if (!sc || !cp_invalid || cp_cnt == CP_LAST) begin
          g_en           <= sg;
          c_en           <= sc & ~cp_invalid;
          b_en           <= sb;
          err_cp         <= sc & cp_invalid;
          datapath_ready <= 1'b1;
          cfg_done       <= 1'b1;
          busy           <= 1'b0;
          state          <= RUN;
        end else cp_cnt <= cp_cnt + 1'b1;
        RUN: if (cfg_start) begin
          {sg, sc, sb}   <= {cfg_g_en, cfg_c_en, cfg_b_en};
          frame_done     <= pix_end;
          datapath_ready <= ~pix_end;
          fl_cnt         <= '0;
          busy           <= 1'b1;
          state          <= DRAIN;
        end
        DRAIN: if (!frame_done) begin
          frame_done     <= pix_end;
          datapath_ready <= ~pix_end;
        end else if (fl_cnt == FL_LAST) begin
          {g_en, c_en, b_en} <= '0;
          lut_rd_addr <= '0;
          rd_v        <= 1'b1;
          state       <= LOAD;
        end else fl_cnt <= fl_cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_datapath_cfg_ctrl.sv
// tb_datapath_cfg_ctrl: directed table-driven bench for the configuration sequencer
module tb_datapath_cfg_ctrl;
  localparam int DW = 8;
  logic clk = 1'b0, resetN = 1'b0, cfg_start = 1'b0;
  logic cfg_g_en = 1'b0, cfg_c_en = 1'b0, cfg_b_en = 1'b0;
  logic cp_invalid = 1'b0, pix_valid_in = 1'b0, pix_last_in = 1'b0;
  logic [DW-1:0] lut_rd_addr, lut_rd_data, glut_from, glut_to;
  logic glut_write_en_n, g_en, c_en, b_en, datapath_ready, busy, cfg_done, err_cp;
  logic [DW-1:0] key = 8'hFF;
  int total = 0, passed = 0;
  typedef struct {
    logic g, c, b, cpi;
    logic eg, ec, eb;
    int   done_at;
    logic err;
  } vec_t;
  vec_t tbl[6];

  datapath_cfg_ctrl dut (
    .clk(clk), .resetN(resetN), .cfg_start(cfg_start),
    .cfg_g_en(cfg_g_en), .cfg_c_en(cfg_c_en), .cfg_b_en(cfg_b_en),
    .lut_rd_addr(lut_rd_addr), .lut_rd_data(lut_rd_data), .cp_invalid(cp_invalid),
    .pix_valid_in(pix_valid_in), .pix_last_in(pix_last_in),
    .glut_write_en_n(glut_write_en_n), .glut_from(glut_from), .glut_to(glut_to),
    .g_en(g_en), .c_en(c_en), .b_en(b_en), .datapath_ready(datapath_ready),
    .busy(busy), .cfg_done(cfg_done), .err_cp(err_cp)
  );

  always #5 clk = ~clk;
  // Config RAM model: one-cycle read latency, contents addr ^ key
  always_ff @(posedge clk) lut_rd_data <= lut_rd_addr ^ key;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    step();
    step();
    resetN = 1'b1;
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {glut_write_en_n, lut_rd_addr, glut_from, glut_to, g_en, c_en, b_en,
                 datapath_ready, busy, cfg_done, err_cp},
          {1'b1, 8'd0, 8'd0, 8'd0, 7'd0});
  endtask

  // Start a configuration from IDLE and watch 280 cycles; cyc counts edges after the start edge
  task automatic do_cfg(input logic g, input logic c, input logic b, input int inj_at,
                        output int nw, output int fw, output int bad, output int done_at,
                        output int err_at, output int dcnt, output logic busy_mid);
    logic inj = 1'b0;
    nw = 0; fw = -1; bad = 0; done_at = -1; err_at = -1; dcnt = 0; busy_mid = 1'b0;
    {cfg_g_en, cfg_c_en, cfg_b_en} = {g, c, b};
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int cyc = 0; cyc < 280; cyc++) begin
      if (!glut_write_en_n) begin
        if (fw < 0) fw = cyc;
        if (glut_from != DW'(nw) || glut_to != (DW'(nw) ^ key) || datapath_ready) bad++;
        nw++;
      end
      if (cfg_done) begin dcnt++; done_at = cyc; end
      if (err_cp) err_at = cyc;
      if (cyc == 100) busy_mid = busy;
      if (!inj && int'(lut_rd_addr) == inj_at) begin
        inj = 1'b1;
        {cfg_g_en, cfg_c_en, cfg_b_en} = ~{g, c, b};
        cfg_start = 1'b1;
      end
      step();
      cfg_start = 1'b0;
    end
  endtask

  // After the frame end edge, watch the flush, reload and return to RUN
  task automatic drain_watch(output int clr_at, output int fw, output int nw, output int bad,
                             output int viol, output int done_at, output int err_at);
    clr_at = -1; fw = -1; nw = 0; bad = 0; viol = 0; done_at = -1; err_at = -1;
    for (int cyc = 1; cyc < 300 && done_at < 0; cyc++) begin
      step();
      if (clr_at < 0 && {g_en, c_en, b_en} == 3'b000) clr_at = cyc;
      if (!glut_write_en_n) begin
        if (fw < 0) fw = cyc;
        if (datapath_ready) viol++;
        if (glut_from != DW'(nw) || glut_to != (DW'(nw) ^ key)) bad++;
        nw++;
      end
      if (err_cp) err_at = cyc;
      if (cfg_done) done_at = cyc;
    end
  endtask

  initial begin
    int nw, fw, bad, done_at, err_at, dcnt, clr_at, viol, early;
    logic busy_mid;
    tbl[0] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 259, 1'b0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 266, 1'b1};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 266, 1'b1};
    tbl[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 259, 1'b0};
    tbl[4] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 259, 1'b0};
    tbl[5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 259, 1'b0};
    step();
    step();
    check_reset_outputs("reset_state");
    resetN = 1'b1;

    foreach (tbl[i]) begin
      do_reset();
      cp_invalid = tbl[i].cpi;
      do_cfg(tbl[i].g, tbl[i].c, tbl[i].b, -1, nw, fw, bad, done_at, err_at, dcnt, busy_mid);
      check($sformatf("v%0d_writes", i), nw, 256);
      check($sformatf("v%0d_first_write", i), fw, 2);
      check($sformatf("v%0d_bad_beats", i), bad, 0);
      check($sformatf("v%0d_done_at", i), done_at, tbl[i].done_at);
      check($sformatf("v%0d_err_at", i), err_at, tbl[i].err ? tbl[i].done_at : -1);
      check($sformatf("v%0d_done_pulses", i), dcnt, 1);
      check($sformatf("v%0d_enables", i), {g_en, c_en, b_en}, {tbl[i].eg, tbl[i].ec, tbl[i].eb});
      check($sformatf("v%0d_ready", i), datapath_ready, 1'b1);
      check($sformatf("v%0d_busy_run", i), busy, 1'b0);
      check($sformatf("v%0d_busy_load", i), busy_mid, 1'b1);
    end

    // Reset in the middle of a load, then a clean restart
    do_reset();
    cp_invalid = 1'b0;
    {cfg_g_en, cfg_c_en, cfg_b_en} = 3'b111;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int i = 0; i < 300 && lut_rd_addr != 8'd50; i++) step();
    check("reach_addr50", lut_rd_addr, 8'd50);
    resetN = 1'b0;
    step();
    check_reset_outputs("mid_load_reset");
    resetN = 1'b1;
    step();
    check("idle_after_reset", {busy, glut_write_en_n}, 2'b01);
    do_cfg(1'b1, 1'b0, 1'b1, -1, nw, fw, bad, done_at, err_at, dcnt, busy_mid);
    check("restart_writes", nw, 256);
    check("restart_first_write", fw, 2);
    check("restart_bad_beats", bad, 0);
    check("restart_enables", {g_en, c_en, b_en}, 3'b101);

    // cfg_start during LOAD at address 100 is ignored
    do_reset();
    do_cfg(1'b1, 1'b0, 1'b1, 100, nw, fw, bad, done_at, err_at, dcnt, busy_mid);
    check("ign_writes", nw, 256);
    check("ign_bad_beats", bad, 0);
    check("ign_done_at", done_at, 259);
    check("ign_done_pulses", dcnt, 1);
    check("ign_enables", {g_en, c_en, b_en}, 3'b101);

    // Reconfigure while streaming: 10 pixel frame, new RAM contents
    key = 8'h3C;
    {cfg_g_en, cfg_c_en, cfg_b_en} = 3'b011;
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    check("drain_entry_ready", datapath_ready, 1'b1);
    check("drain_entry_busy", busy, 1'b1);
    check("drain_entry_enables", {g_en, c_en, b_en}, 3'b101);
    early = 0;
    for (int i = 0; i < 10; i++) begin
      pix_valid_in = 1'b1;
      pix_last_in = (i == 9);
      step();
      if (i < 9 && !datapath_ready) early++;
    end
    pix_valid_in = 1'b0;
    pix_last_in = 1'b0;
    check("drain_early_drop", early, 0);
    check("drain_ready_drop", datapath_ready, 1'b0);
    drain_watch(clr_at, fw, nw, bad, viol, done_at, err_at);
    check("drain_clear_at", clr_at, 5);
    check("drain_first_write", fw, 7);
    check("drain_writes", nw, 256);
    check("drain_bad_beats", bad, 0);
    check("drain_write_while_ready", viol, 0);
    check("drain_done_at", done_at, 264);
    check("drain_err_at", err_at, -1);
    check("drain_enables", {g_en, c_en, b_en, datapath_ready}, 4'b0111);

    // Frame end coincident with cfg_start, contrast timeout on reload
    key = 8'hA5;
    cp_invalid = 1'b1;
    {cfg_g_en, cfg_c_en, cfg_b_en} = 3'b110;
    cfg_start = 1'b1;
    pix_valid_in = 1'b1;
    pix_last_in = 1'b1;
    step();
    cfg_start = 1'b0;
    pix_valid_in = 1'b0;
    pix_last_in = 1'b0;
    check("coinc_ready", datapath_ready, 1'b0);
    check("coinc_busy", busy, 1'b1);
    check("coinc_enables", {g_en, c_en, b_en}, 3'b011);
    drain_watch(clr_at, fw, nw, bad, viol, done_at, err_at);
    check("coinc_clear_at", clr_at, 5);
    check("coinc_first_write", fw, 7);
    check("coinc_writes", nw, 256);
    check("coinc_bad_beats", bad, 0);
    check("coinc_done_at", done_at, 271);
    check("coinc_err_at", err_at, 271);
    check("coinc_enables_run", {g_en, c_en, b_en, datapath_ready}, 4'b1001);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
